// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types, defaults and helpers for the PISO serializer
// Purpose: state encoding, default word width and bit-count width helper.
// Ports: none (package).
package piso_pkg;

    localparam int PISO_WIDTH_DEFAULT = 8;

    // 1-bit legacy-compatible encoding: SHIFT doubles as "shifter occupied"
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Width of the per-word bit counter; at least one bit for WIDTH==2
    function automatic int piso_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_hold_buffer.sv
// rtl/piso_hold_buffer.sv - one-deep word holding register with full flag
// Purpose: parks the next word while the shifter is still sending the current one.
// Ports:
//   clock, reset_n    clock and asynchronous active-low reset
//   i_wr, i_wdata     write a word (only issued while empty)
//   i_take            shifter takes the held word (only issued while full)
//   o_rdata, o_full   held word and occupancy flag
module piso_hold_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_take,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_wr) begin
                r_data <= i_wdata;
                r_full <= 1'b1;
            end else if (i_take) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_rdata = r_data;
    assign o_full  = r_full;

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out transmitter with one-word holding buffer
// Purpose: accepts WIDTH-bit words and sends them one bit per ser_valid&&ser_ready beat,
//          back-to-back without bubbles when a word waits in the holding buffer.
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   data_in, load           parallel word and its valid strobe
//   load_ready              word accepted on edge when load && load_ready
//   ser_out, ser_valid      serial bit and its valid flag
//   ser_ready               sink consumes bit on edge when ser_valid && ser_ready
//   ser_last                ser_out is the final bit of the current word
//   busy                    shifter or holding buffer occupied
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    localparam int             CW       = piso_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    piso_state_t      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_ser_valid, w_valid_nxt;
    logic             r_ser_last, w_last_nxt;
    logic             r_busy, w_busy_nxt;

    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_full, w_hold_full_nxt;
    logic             w_accept, w_beat, w_last_beat;
    logic             w_hold_wr, w_hold_take, w_load_shift;

    // load_ready is purely the inverted hold flag, so it never sees load/ser_ready
    assign load_ready  = !w_hold_full;
    assign w_accept    = load && load_ready;
    assign w_beat      = r_ser_valid && ser_ready;
    assign w_last_beat = w_beat && r_ser_last;

    // A load goes to the shifter if it is empty or vacating this edge; otherwise
    // it is parked. Hold full implies load_ready=0, so the two never collide.
    assign w_load_shift = w_accept && (!r_ser_valid || w_last_beat);
    assign w_hold_wr    = w_accept && r_ser_valid && !w_last_beat;
    assign w_hold_take  = w_last_beat && w_hold_full;

    piso_hold_buffer #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock   (clock),
        .reset_n (reset_n),
        .i_wr    (w_hold_wr),
        .i_wdata (data_in),
        .i_take  (w_hold_take),
        .o_rdata (w_hold_data),
        .o_full  (w_hold_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_valid_nxt = r_ser_valid;
        w_last_nxt  = r_ser_last;
        if (w_hold_take) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = w_hold_data;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b0;
        end else if (w_load_shift) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = data_in;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b0;
        end else if (w_last_beat) begin
            // Clearing the shifter forces ser_out low while idle
            w_state_nxt = IDLE;
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
        end else if (w_beat) begin
            w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shift[WIDTH-1:1]};
            w_cnt_nxt   = r_cnt + CW'(1);
            w_last_nxt  = ((r_cnt + CW'(1)) == LAST_CNT);
        end
        w_hold_full_nxt = w_hold_wr || (w_hold_full && !w_hold_take);
        w_busy_nxt      = (w_state_nxt == SHIFT) || w_hold_full_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ser_valid <= w_valid_nxt;
            r_ser_last  <= w_last_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign ser_out   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

    logic       clock = 1'b0;
    logic       reset_n;

    logic [7:0] data_a, data_b;
    logic       load_a, load_b, ready_a, ready_b;
    logic       lrdy_a, sout_a, sval_a, slast_a, busy_a;
    logic       lrdy_b, sout_b, sval_b, slast_b, busy_b;

    int checks = 0;
    int errors = 0;
    int vcnt;

    logic [7:0]  w_a5 = 8'b1010_0101;
    logic [7:0]  w_f0 = 8'b1111_0000;
    logic [7:0]  w_01 = 8'b0000_0001;
    logic [15:0] w_pair = 16'b1010_0101_0011_1100;

    always #5 clock = ~clock;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset_n(reset_n), .data_in(data_a), .load(load_a),
        .load_ready(lrdy_a), .ser_out(sout_a), .ser_valid(sval_a),
        .ser_ready(ready_a), .ser_last(slast_a), .busy(busy_a)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset_n(reset_n), .data_in(data_b), .load(load_b),
        .load_ready(lrdy_b), .ser_out(sout_b), .ser_valid(sval_b),
        .ser_ready(ready_b), .ser_last(slast_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_valid"}, 32'(sval_a), 32'd0);
        chk({tag, "_out"},   32'(sout_a), 32'd0);
        chk({tag, "_last"},  32'(slast_a), 32'd0);
        chk({tag, "_busy"},  32'(busy_a), 32'd0);
        chk({tag, "_lrdy"},  32'(lrdy_a), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        data_a = '0; data_b = '0;
        load_a = 1'b0; load_b = 1'b0;
        ready_a = 1'b0; ready_b = 1'b0;
        repeat (3) tick();
        chk_idle_a("rst");
        chk("rst_b_valid", 32'(sval_b), 32'd0);
        chk("rst_b_lrdy",  32'(lrdy_b), 32'd1);
        reset_n = 1'b1;
        tick();

        // Single word A5, MSB first
        data_a = 8'hA5; load_a = 1'b1; ready_a = 1'b1;
        tick();
        load_a = 1'b0;
        chk("t2_lrdy", 32'(lrdy_a), 32'd1);
        chk("t2_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_valid%0d", i), 32'(sval_a), 32'd1);
            chk($sformatf("t2_bit%0d", i), 32'(sout_a), 32'(w_a5[7-i]));
            chk($sformatf("t2_last%0d", i), 32'(slast_a), 32'(i == 7));
            tick();
        end
        chk_idle_a("t2_end");

        // Back-to-back A5 then 3C
        data_a = 8'hA5; load_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_valid%0d", i), 32'(sval_a), 32'd1);
            chk($sformatf("t3_bit%0d", i), 32'(sout_a), 32'(w_pair[15-i]));
            chk($sformatf("t3_last%0d", i), 32'(slast_a), 32'((i == 7) || (i == 15)));
            if (i == 1) chk("t3_lrdy_full", 32'(lrdy_a), 32'd0);
            if (i == 8) chk("t3_lrdy_free", 32'(lrdy_a), 32'd1);
            if (i == 0) begin
                data_a = 8'h3C; load_a = 1'b1;
            end else begin
                load_a = 1'b0;
            end
            tick();
        end
        chk_idle_a("t3_end");

        // Stall 5 cycles at bit 3 of F0
        data_a = 8'hF0; load_a = 1'b1;
        tick();
        load_a = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                ready_a = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    if (sval_a) vcnt++;
                    chk($sformatf("t4_stall_bit%0d", s), 32'(sout_a), 32'd1);
                    chk($sformatf("t4_stall_last%0d", s), 32'(slast_a), 32'd0);
                    tick();
                end
                ready_a = 1'b1;
            end
            if (sval_a) vcnt++;
            chk($sformatf("t4_bit%0d", i), 32'(sout_a), 32'(w_f0[7-i]));
            chk($sformatf("t4_last%0d", i), 32'(slast_a), 32'(i == 7));
            tick();
        end
        chk("t4_valid_cycles", 32'(vcnt), 32'd13);
        chk_idle_a("t4_end");

        // LSB-first instance, word 01
        data_b = 8'h01; load_b = 1'b1; ready_b = 1'b1;
        tick();
        load_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_valid%0d", i), 32'(sval_b), 32'd1);
            chk($sformatf("t5_bit%0d", i), 32'(sout_b), 32'(w_01[i]));
            chk($sformatf("t5_last%0d", i), 32'(slast_b), 32'(i == 7));
            tick();
        end
        chk("t5_end_valid", 32'(sval_b), 32'd0);
        chk("t5_end_busy",  32'(busy_b), 32'd0);

        // Dropped load while hold full, then reset during bit 4 of second word
        data_a = 8'hA5; load_a = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t6_bit%0d", i), 32'(sout_a), 32'(w_pair[15-i]));
            chk($sformatf("t6_valid%0d", i), 32'(sval_a), 32'd1);
            if (i == 8) chk("t6_lrdy_free", 32'(lrdy_a), 32'd1);
            if (i == 0) begin
                data_a = 8'h3C; load_a = 1'b1;
            end else if (i == 1 || i == 2) begin
                chk($sformatf("t6_lrdy_full%0d", i), 32'(lrdy_a), 32'd0);
                data_a = 8'hFF; load_a = 1'b1;
            end else begin
                load_a = 1'b0;
            end
            tick();
        end
        chk("t6_bit12", 32'(sout_a), 32'(w_pair[3]));
        chk("t6_busy12", 32'(busy_a), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_idle_a("t6_async_rst");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t6_post_valid%0d", i), 32'(sval_a), 32'd0);
            chk($sformatf("t6_post_busy%0d", i), 32'(busy_a), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
